// File: rtl/sevenseg_scan_driver.sv
// sevenseg_scan_driver
//   Multiplexed seven-segment driver. Scans DIGITS hex digits one slot at a
//   time with one-hot, active-high digit grounds and registered segment
//   outputs. Adds per-digit blanking, decimal points, frame-synchronous
//   (tear-free) data updates and a frame pulse.
//
//   Optional feature: define SEVSEG_LZ_BLANK_EN for leading-zero suppression.
//   With the macro, digit i is blanked when its nibble and all nibbles left
//   of it are zero; the rightmost digit is never suppressed.
//
// Parameters
//   DIGITS       digits scanned (2..8), din is 4*DIGITS wide
//   REFRESH_DIV  clk cycles per digit slot (>=2)
//   SEG_ACT_LOW  1: a 0 on display/dp lights the segment, 0: a 1 lights it
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active-high
//   din         hex value, nibble [4*DIGITS-1 -: 4] is digit 0 (leftmost)
//   din_load    one-cycle strobe capturing din, dp_in, digit_en
//   dp_in       decimal point per digit (bit i -> digit i), 1 = lit
//   digit_en    1 = digit shown, 0 = digit blanked
//   grounds     one-hot digit select, active-high
//   display     segments a..g, MSB = a
//   dp          decimal point of the selected digit
//   frame_tick  one-cycle pulse when the scan returns to digit 0
module sevenseg_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 32768,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] din,
  input  logic                din_load,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic [DIGITS-1:0]   digit_en,
  output logic [DIGITS-1:0]   grounds,
  output logic [6:0]          display,
  output logic                dp,
  output logic                frame_tick
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // Segment pattern in lit form (1 = segment on), a..g with a as MSB.
  function automatic logic [6:0] hex_lit(input logic [3:0] nib);
    logic [6:0] al;
    case (nib)
      4'h0: al = 7'b0000001;
      4'h1: al = 7'b1001111;
      4'h2: al = 7'b0010010;
      4'h3: al = 7'b0000110;
      4'h4: al = 7'b1001100;
      4'h5: al = 7'b0100100;
      4'h6: al = 7'b0100000;
      4'h7: al = 7'b0001111;
      4'h8: al = 7'b0000000;
      4'h9: al = 7'b0000100;
      4'hA: al = 7'b0001000;
      4'hB: al = 7'b1100000;
      4'hC: al = 7'b0110001;
      4'hD: al = 7'b1000010;
      4'hE: al = 7'b0110000;
      default: al = 7'b0111000;
    endcase
    return ~al;
  endfunction

  // Convert lit form to the board pin polarity.
  function automatic logic [6:0] seg_pins(input logic [6:0] lit);
    return lit ^ {7{SEG_ACT_LOW}};
  endfunction

  function automatic logic dp_pin(input logic lit);
    return lit ^ SEG_ACT_LOW;
  endfunction

  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_nxt;
  logic                slot_tick;
  logic                wrap_tick;

  logic [4*DIGITS-1:0] pend_din;
  logic [DIGITS-1:0]   pend_dp;
  logic [DIGITS-1:0]   pend_en;
  logic [4*DIGITS-1:0] shown_din;
  logic [DIGITS-1:0]   shown_dp;
  logic [DIGITS-1:0]   shown_en;
  logic [4*DIGITS-1:0] shown_din_nxt;
  logic [DIGITS-1:0]   shown_dp_nxt;
  logic [DIGITS-1:0]   shown_en_nxt;

  logic [DIGITS-1:0]   grounds_nxt;
  logic [3:0]          sel_nib;
  logic                sel_en;
  logic                sel_dp;
  logic                sel_lz;
  logic [6:0]          seg_lit;
  logic                dp_lit;

  always_comb begin
    slot_tick = (cnt == CNT_LAST);
    wrap_tick = slot_tick && (idx == IDX_LAST);
    idx_nxt   = wrap_tick ? '0 : idx + IDX_W'(1);
  end

  // Shown data only moves at the frame wrap; a load landing on that very
  // cycle bypasses pending so it is visible in the next slot.
  always_comb begin
    shown_din_nxt = shown_din;
    shown_dp_nxt  = shown_dp;
    shown_en_nxt  = shown_en;
    if (wrap_tick) begin
      if (din_load) begin
        shown_din_nxt = din;
        shown_dp_nxt  = dp_in;
        shown_en_nxt  = digit_en;
      end else begin
        shown_din_nxt = pend_din;
        shown_dp_nxt  = pend_dp;
        shown_en_nxt  = pend_en;
      end
    end
  end

  // Select the digit entering the next slot from the data it will show.
  always_comb begin : sel_blk
    logic lz_run;
    lz_run      = 1'b1;
    grounds_nxt = '0;
    sel_nib     = '0;
    sel_en      = 1'b0;
    sel_dp      = 1'b0;
    sel_lz      = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      lz_run         = lz_run && (shown_din_nxt[4*(DIGITS-1-i) +: 4] == 4'h0);
      grounds_nxt[i] = (IDX_W'(i) == idx_nxt);
      if (IDX_W'(i) == idx_nxt) begin
        sel_nib = shown_din_nxt[4*(DIGITS-1-i) +: 4];
        sel_en  = shown_en_nxt[i];
        sel_dp  = shown_dp_nxt[i];
`ifdef SEVSEG_LZ_BLANK_EN
        sel_lz  = lz_run && (i != DIGITS - 1);
`endif
      end
    end
    seg_lit = (sel_en && !sel_lz) ? hex_lit(sel_nib) : 7'b0;
    dp_lit  = sel_en && sel_dp;
  end

  // Register stage: counters, buffers and pin outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      pend_din   <= '0;
      pend_dp    <= '0;
      pend_en    <= '0;
      shown_din  <= '0;
      shown_dp   <= '0;
      shown_en   <= '0;
      grounds    <= DIGITS'(1);
      display    <= seg_pins(7'b0);
      dp         <= dp_pin(1'b0);
      frame_tick <= 1'b0;
    end else begin
      cnt        <= slot_tick ? '0 : cnt + CNT_W'(1);
      frame_tick <= wrap_tick;
      shown_din  <= shown_din_nxt;
      shown_dp   <= shown_dp_nxt;
      shown_en   <= shown_en_nxt;
      if (din_load) begin
        pend_din <= din;
        pend_dp  <= dp_in;
        pend_en  <= digit_en;
      end
      if (slot_tick) begin
        idx     <= idx_nxt;
        grounds <= grounds_nxt;
        display <= seg_pins(seg_lit);
        dp      <= dp_pin(dp_lit);
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
module tb_sevenseg_scan_driver;

  // Active-low segment codes for 0..F, a..g with a as MSB.
  localparam logic [6:0] CODES [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  logic clk = 1'b0;
  logic rst = 1'b0;

  // Instance A: 4 digits, 4 clk per slot, active-low pins.
  logic [15:0] din_a = '0;
  logic        ld_a  = 1'b0;
  logic [3:0]  dpi_a = '0;
  logic [3:0]  en_a  = '0;
  logic [3:0]  g_a;
  logic [6:0]  disp_a;
  logic        dp_a;
  logic        fr_a;

  // Instance B: 8 digits, 2 clk per slot, active-high pins.
  logic [31:0] din_b = '0;
  logic        ld_b  = 1'b0;
  logic [7:0]  dpi_b = '0;
  logic [7:0]  en_b  = '0;
  logic [7:0]  g_b;
  logic [6:0]  disp_b;
  logic        dp_b;
  logic        fr_b;

  sevenseg_scan_driver #(.DIGITS(4), .REFRESH_DIV(4), .SEG_ACT_LOW(1'b1)) u_a (
    .clk(clk), .rst(rst), .din(din_a), .din_load(ld_a), .dp_in(dpi_a),
    .digit_en(en_a), .grounds(g_a), .display(disp_a), .dp(dp_a), .frame_tick(fr_a));

  sevenseg_scan_driver #(.DIGITS(8), .REFRESH_DIV(2), .SEG_ACT_LOW(1'b0)) u_b (
    .clk(clk), .rst(rst), .din(din_b), .din_load(ld_b), .dp_in(dpi_b),
    .digit_en(en_b), .grounds(g_b), .display(disp_b), .dp(dp_b), .frame_tick(fr_b));

  always #5 clk = ~clk;

  wire [12:0] obs_a = {g_a, disp_a, dp_a, fr_a};
  wire [16:0] obs_b = {g_b, disp_b, dp_b, fr_b};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: k = clock edges since reset release.
  int          ka, kb;
  logic [15:0] pa_din, sa_din;
  logic [3:0]  pa_dp, pa_en, sa_dp, sa_en;
  logic [31:0] pb_din, sb_din;
  logic [7:0]  pb_dp, pb_en, sb_dp, sb_en;
  logic [12:0] exp_a;
  logic [16:0] exp_b;

  // Next-cycle requests driven by tick().
  logic        rq_la = 1'b0, rq_lb = 1'b0;
  logic [15:0] rq_da = '0;
  logic [3:0]  rq_dpa = '0, rq_ena = '0;
  logic [31:0] rq_db = '0;
  logic [7:0]  rq_dpb = '0, rq_enb = '0;

  // Expected {grounds(8), display, dp, frame_tick} after k edges.
  function automatic logic [16:0] model_out(input int digits, input int rd, input bit actlow,
                                            input int k, input logic [31:0] sdin,
                                            input logic [7:0] sdp, input logic [7:0] sen);
    int         idx;
    logic [7:0] g;
    logic [3:0] nib;
    logic [6:0] seg;
    logic       on, dpl, fr;
`ifdef SEVSEG_LZ_BLANK_EN
    bit         allz;
`endif
    idx = (k / rd) % digits;
    g   = 8'd1 << idx;
    fr  = (k > 0) && (k % (rd * digits) == 0);
    nib = sdin[4*(digits-1-idx) +: 4];
    on  = sen[idx];
`ifdef SEVSEG_LZ_BLANK_EN
    if (idx != digits - 1) begin
      allz = 1'b1;
      for (int j = 0; j <= idx; j++)
        if (sdin[4*(digits-1-j) +: 4] != 4'h0) allz = 1'b0;
      if (allz) on = 1'b0;
    end
`endif
    seg = on ? CODES[nib] : 7'h7F;
    dpl = sen[idx] & sdp[idx];
    if (actlow) return {g, seg, ~dpl, fr};
    return {g, ~seg, dpl, fr};
  endfunction

  task automatic model_reset();
    ka = 0; kb = 0;
    pa_din = '0; pa_dp = '0; pa_en = '0; sa_din = '0; sa_dp = '0; sa_en = '0;
    pb_din = '0; pb_dp = '0; pb_en = '0; sb_din = '0; sb_dp = '0; sb_en = '0;
    exp_a = 13'(model_out(4, 4, 1'b1, 0, '0, '0, '0));
    exp_b = model_out(8, 2, 1'b0, 0, '0, '0, '0);
  endtask

  // One clock: drive requests, step the model, settle for sampling.
  task automatic tick();
    @(negedge clk);
    din_a = rq_da; ld_a = rq_la; dpi_a = rq_dpa; en_a = rq_ena;
    din_b = rq_db; ld_b = rq_lb; dpi_b = rq_dpb; en_b = rq_enb;
    @(posedge clk);
    ka++;
    if (ka % 16 == 0) begin
      if (rq_la) {sa_din, sa_dp, sa_en} = {rq_da, rq_dpa, rq_ena};
      else       {sa_din, sa_dp, sa_en} = {pa_din, pa_dp, pa_en};
    end
    if (rq_la) {pa_din, pa_dp, pa_en} = {rq_da, rq_dpa, rq_ena};
    kb++;
    if (kb % 16 == 0) begin
      if (rq_lb) {sb_din, sb_dp, sb_en} = {rq_db, rq_dpb, rq_enb};
      else       {sb_din, sb_dp, sb_en} = {pb_din, pb_dp, pb_en};
    end
    if (rq_lb) {pb_din, pb_dp, pb_en} = {rq_db, rq_dpb, rq_enb};
    rq_la = 1'b0; rq_lb = 1'b0;
    #1;
    ld_a = 1'b0; ld_b = 1'b0;
    exp_a = 13'(model_out(4, 4, 1'b1, ka, {16'h0, sa_din}, {4'h0, sa_dp}, {4'h0, sa_en}));
    exp_b = model_out(8, 2, 1'b0, kb, sb_din, sb_dp, sb_en);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (obs_a !== exp_a) begin
      n_fail++; $display("FAIL reset_a: got %b expected %b", obs_a, exp_a);
    end
    n_checks++;
    if (obs_b !== exp_b) begin
      n_fail++; $display("FAIL reset_b: got %b expected %b", obs_b, exp_b);
    end
    // A load held during reset must be ignored.
    din_a = 16'hFFFF; dpi_a = 4'hF; en_a = 4'hF; ld_a = 1'b1;
    @(posedge clk);
    #1 ld_a = 1'b0; rst = 1'b0;
    repeat (20) begin
      tick();
      n_checks++;
      if (obs_a !== exp_a) begin
        n_fail++; $display("FAIL reset_load_ignored k=%0d: got %b expected %b", ka, obs_a, exp_a);
      end
    end
  endtask

  task automatic test_basic();
    rq_la = 1'b1; rq_da = 16'h1A2F; rq_dpa = 4'h0; rq_ena = 4'hF;
    repeat (40) begin
      tick();
      n_checks++;
      if (obs_a !== exp_a) begin
        n_fail++; $display("FAIL basic k=%0d: got %b expected %b", ka, obs_a, exp_a);
      end
    end
  endtask

  task automatic test_double_buffer();
    int fcount;
    while (ka % 16 != 4) tick();
    rq_la = 1'b1; rq_da = 16'h1234; rq_dpa = 4'h0; rq_ena = 4'hF;
    repeat (4) tick();
    rq_la = 1'b1; rq_da = 16'hBEEF;
    fcount = 0;
    repeat (32) begin
      tick();
      if (fr_a === 1'b1) fcount++;
      n_checks++;
      if (obs_a !== exp_a) begin
        n_fail++; $display("FAIL double_buffer k=%0d: got %b expected %b", ka, obs_a, exp_a);
      end
    end
    n_checks++;
    if (fcount !== 2) begin
      n_fail++; $display("FAIL frame_count: got %0d expected 2", fcount);
    end
  endtask

  task automatic test_blank_dp();
    rq_la = 1'b1; rq_da = 16'h1234; rq_dpa = 4'b0011; rq_ena = 4'b0101;
    repeat (36) begin
      tick();
      n_checks++;
      if (obs_a !== exp_a) begin
        n_fail++; $display("FAIL blank_dp k=%0d: got %b expected %b", ka, obs_a, exp_a);
      end
    end
  endtask

  task automatic test_reset_midscan();
    while (ka % 16 != 9) tick();
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (obs_a !== exp_a) begin
      n_fail++; $display("FAIL async_reset_a: got %b expected %b", obs_a, exp_a);
    end
    n_checks++;
    if (obs_b !== exp_b) begin
      n_fail++; $display("FAIL async_reset_b: got %b expected %b", obs_b, exp_b);
    end
    din_a = 16'($urandom); en_a = 4'hF; ld_a = 1'b1;
    repeat (2) @(posedge clk);
    #1 ld_a = 1'b0; rst = 1'b0;
    repeat (24) begin
      tick();
      n_checks++;
      if (obs_a !== exp_a) begin
        n_fail++; $display("FAIL after_reset k=%0d: got %b expected %b", ka, obs_a, exp_a);
      end
    end
  endtask

  task automatic test_lz();
    rq_la = 1'b1; rq_da = 16'h0050; rq_dpa = 4'b0100; rq_ena = 4'hF;
    repeat (34) begin
      tick();
      n_checks++;
      if (obs_a !== exp_a) begin
        n_fail++; $display("FAIL lz_0050 k=%0d: got %b expected %b", ka, obs_a, exp_a);
      end
    end
    rq_la = 1'b1; rq_da = 16'h0000; rq_dpa = 4'b0000;
    repeat (34) begin
      tick();
      n_checks++;
      if (obs_a !== exp_a) begin
        n_fail++; $display("FAIL lz_0000 k=%0d: got %b expected %b", ka, obs_a, exp_a);
      end
    end
  endtask

  task automatic test_wrap_load();
    for (int r = 0; r < 3; r++) begin
      while ((ka + 1) % 16 != 0) tick();
      rq_la = 1'b1; rq_da = 16'($urandom); rq_dpa = 4'($urandom); rq_ena = 4'hF;
      rq_lb = 1'b1; rq_db = $urandom; rq_dpb = 8'($urandom); rq_enb = 8'($urandom) | 8'h01;
      repeat (17) begin
        tick();
        n_checks++;
        if (obs_a !== exp_a) begin
          n_fail++; $display("FAIL wrap_load_a k=%0d: got %b expected %b", ka, obs_a, exp_a);
        end
        n_checks++;
        if (obs_b !== exp_b) begin
          n_fail++; $display("FAIL wrap_load_b k=%0d: got %b expected %b", kb, obs_b, exp_b);
        end
      end
    end
  endtask

  task automatic test_random();
    repeat (400) begin
      if ($urandom_range(3) == 0) begin
        rq_la = 1'b1; rq_da = 16'($urandom >> $urandom_range(16));
        rq_dpa = 4'($urandom); rq_ena = 4'($urandom);
      end
      if ($urandom_range(3) == 0) begin
        rq_lb = 1'b1; rq_db = $urandom >> $urandom_range(32);
        rq_dpb = 8'($urandom); rq_enb = 8'($urandom);
      end
      tick();
      n_checks++;
      if (obs_a !== exp_a) begin
        n_fail++; $display("FAIL random_a k=%0d: got %b expected %b", ka, obs_a, exp_a);
      end
      n_checks++;
      if (obs_b !== exp_b) begin
        n_fail++; $display("FAIL random_b k=%0d: got %b expected %b", kb, obs_b, exp_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_double_buffer();
    test_blank_dp();
    test_reset_midscan();
    test_lz();
    test_wrap_load();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
